down_counter: RTL and testbench

Synchronous, loadable down counter with one-shot and auto-reload modes and a registered terminal-count pulse. It complements the team's ripple up-counter: software or a controller loads a start value, the block counts toward zero on enabled cycles and flags expiry. Its first use is as a programmable interval timer and delay generator. All state changes on the rising edge of one clock.

---
 rtl/down_counter_if.sv | 28 ++
 rtl/down_counter.sv | 102 ++++++++++
 tb/tb_down_counter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/down_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_if
// Brief    : Control and status bundle for the loadable down counter.
// Revision : 1.0
// ============================================================================
interface down_counter_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             busy;

  modport master (
    output load, load_value, enable, auto_reload,
    input  Q, tc, busy
  );

  modport slave (
    input  load, load_value, enable, auto_reload,
    output Q, tc, busy
  );
endinterface
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
// Module   : down_counter
// Brief    : Loadable down counter with one-shot / auto-reload modes and a
//            registered one-cycle terminal-count pulse.
// Revision : 1.0
// ============================================================================
module down_counter #(
  parameter int WIDTH = 4
) (
  input  wire           clk,
  input  wire           clear,
  down_counter_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_EXPIRED = 2'd2;

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q,     tc_d;
  logic             busy_q,   busy_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    busy_d   = busy_q;

    if (clear) begin
      state_d  = S_IDLE;
      count_d  = C_ZERO;
      reload_d = C_ZERO;
      busy_d   = 1'b0;
    end else if (bus.load) begin
      count_d  = bus.load_value;
      reload_d = bus.load_value;
      // A zero load has nothing to count, so it parks in IDLE without a tc.
      if (bus.load_value != C_ZERO) begin
        state_d = S_RUN;
        busy_d  = 1'b1;
      end else begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_d = 1'b0;
        end
        S_RUN: begin
          if (bus.enable) begin
            if (count_q <= C_ONE) begin
              count_d = C_ZERO;
              tc_d    = 1'b1;
              busy_d  = 1'b0;
              state_d = S_EXPIRED;
            end else begin
              count_d = count_q - C_ONE;
            end
          end
        end
        S_EXPIRED: begin
          // auto_reload only matters here, on the edge leaving EXPIRED.
          if (bus.auto_reload) begin
            count_d = reload_q;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = C_ZERO;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    count_q  <= count_d;
    reload_q <= reload_d;
    tc_q     <= tc_d;
    busy_q   <= busy_d;
  end

  assign bus.Q    = count_q;
  assign bus.tc   = tc_q;
  assign bus.busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_down_counter
// Brief    : Directed scenarios plus random stimulus against a reference model.
// Revision : 1.0
// ============================================================================
module tb_down_counter;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic clear;
  int   total = 0;
  int   bad   = 0;

  down_counter_if #(.WIDTH(WIDTH)) bus ();

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: remaining count, last load, pulse flag and counting flag.
  int m_q      = 0;
  int m_reload = 0;
  bit m_tc     = 1'b0;
  bit m_busy   = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit c, input bit l, input int lv, input bit e, input bit a);
    clear           = c;
    bus.load        = l;
    bus.load_value  = lv[WIDTH-1:0];
    bus.enable      = e;
    bus.auto_reload = a;
    @(posedge clk);
    if (c) begin
      m_q = 0; m_reload = 0; m_tc = 0; m_busy = 0;
    end else if (l) begin
      m_q = lv; m_reload = lv; m_tc = 0; m_busy = (lv != 0);
    end else if (m_tc) begin
      m_tc = 0;
      if (a) begin
        m_q = m_reload; m_busy = 1;
      end
    end else if (m_busy && e) begin
      m_q = m_q - 1;
      if (m_q == 0) begin
        m_tc = 1; m_busy = 0;
      end
    end
    #1;
    chk("q",    int'(bus.Q),    m_q);
    chk("tc",   int'(bus.tc),   int'(m_tc));
    chk("busy", int'(bus.busy), int'(m_busy));
    if (bus.tc) chk("tc_q_zero", int'(bus.Q), 0);
  endtask

  initial begin
    clear = 1'b1; bus.load = 1'b0; bus.load_value = '0;
    bus.enable = 1'b0; bus.auto_reload = 1'b0;

    // Reset: clear beats a simultaneous load of 5
    repeat (2) begin
      step(1, 1, 5, 0, 0);
      chk("rst_q", int'(bus.Q), 0);
      chk("rst_busy", int'(bus.busy), 0);
    end

    // One-shot count from 3
    step(0, 1, 3, 0, 0);
    chk("os_load", int'(bus.Q), 3);
    step(0, 0, 0, 1, 0); chk("os_2", int'(bus.Q), 2);
    step(0, 0, 0, 1, 0); chk("os_1", int'(bus.Q), 1);
    step(0, 0, 0, 1, 0); chk("os_tc", int'(bus.tc), 1);
    chk("os_busy_fall", int'(bus.busy), 0);
    repeat (4) begin
      step(0, 0, 0, 1, 0);
      chk("os_hold", int'(bus.Q), 0);
      chk("os_tc_low", int'(bus.tc), 0);
    end

    // Periodic with an enable gap: 2,1,1,0(tc),2
    step(0, 1, 2, 0, 1);
    step(0, 0, 0, 1, 1); chk("per_1", int'(bus.Q), 1);
    step(0, 0, 0, 0, 1); chk("per_gap", int'(bus.Q), 1);
    step(0, 0, 0, 1, 1); chk("per_tc", int'(bus.tc), 1);
    step(0, 0, 0, 1, 1); chk("per_reload", int'(bus.Q), 2);
    chk("per_tc_width", int'(bus.tc), 0);
    step(0, 0, 0, 1, 1);

    // Load priority over counting, then load 0 in RUN
    step(0, 1, 6, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0); chk("lp_at4", int'(bus.Q), 4);
    step(0, 1, 9, 1, 0); chk("lp_9", int'(bus.Q), 9);
    step(0, 1, 0, 1, 0); chk("lp_zero_busy", int'(bus.busy), 0);
    repeat (3) begin
      step(0, 0, 0, 1, 1);
      chk("lp_zero_tc", int'(bus.tc), 0);
    end

    // Mid-count clear, then new value reloads rather than 15
    step(0, 1, 15, 0, 0);
    repeat (8) step(0, 0, 0, 1, 0);
    chk("mc_at7", int'(bus.Q), 7);
    step(1, 0, 0, 1, 0); chk("mc_clear", int'(bus.Q), 0);
    step(0, 0, 0, 1, 1); chk("mc_idle", int'(bus.Q), 0);
    step(0, 1, 3, 0, 1);
    repeat (3) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1); chk("mc_reload", int'(bus.Q), 3);

    // Load during EXPIRED
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0); chk("le_tc", int'(bus.tc), 1);
    step(0, 1, 6, 1, 0);
    chk("le_q", int'(bus.Q), 6);
    chk("le_busy", int'(bus.busy), 1);

    // Maximum count with auto-reload
    step(0, 1, 15, 0, 1);
    repeat (15) step(0, 0, 0, 1, 1);
    chk("max_tc", int'(bus.tc), 1);
    step(0, 0, 0, 0, 1); chk("max_reload", int'(bus.Q), 15);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit c, l, e, a;
      int lv;
      c  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 8);
      e  = ($urandom_range(0, 99) < 75);
      a  = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0:       lv = 0;
        1:       lv = 15;
        default: lv = $urandom_range(1, 6);
      endcase
      step(c, l, lv, e, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
